// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// from the IR opcode and drives the datapath muxes, write enables and aluOp.
module multicycle_control #(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                memReady,
  output logic [3:0]          state,
  output logic [ALU_OP_W-1:0] aluOp,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic                zeroExt,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic [1:0]          pcSource,
  output logic                iOrD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                regDst,
  output logic                memToReg,
  output logic                regWrite,
  output logic [1:0]          ldMode,
  output logic                illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(3'b100);

  state_t     cur;
  logic [5:0] opq;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                    return R_EXEC;
      OP_LW, OP_SW, OP_LH, OP_LHU: return MEM_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI:    return I_EXEC;
      OP_BEQ:                      return BRANCH;
      OP_J:                        return JUMP;
      default:                     return ILLEGAL;
    endcase
  endfunction

  function automatic logic [1:0] load_mode(input logic [5:0] op);
    case (op)
      OP_LH:   return 2'b10;
      OP_LHU:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Next-state register; opq latches the opcode once the IR is valid in DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= FETCH;
      opq <= '0;
    end else begin
      case (cur)
        FETCH:     if (memReady) cur <= DECODE;
        DECODE: begin
          opq <= opcode;
          cur <= decode_next(opcode);
        end
        MEM_ADDR:  cur <= (opq == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (memReady) cur <= MEM_WB;
        MEM_WRITE: if (memReady) cur <= FETCH;
        R_EXEC:    cur <= R_WB;
        I_EXEC:    cur <= I_WB;
        default:   cur <= FETCH;
      endcase
    end
  end

  assign state = cur;

  // Moore decode; the whole control word is held at zero while reset is low.
  always_comb begin
    aluOp       = ALU_ADD;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    zeroExt     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 2'b00;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    ldMode      = 2'b00;
    illegal     = 1'b0;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcWrite = memReady;
        end
        DECODE: aluSrcB = 2'b11;
        MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        MEM_READ: begin
          memRead = 1'b1;
          iOrD    = 1'b1;
        end
        MEM_WB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          ldMode   = load_mode(opq);
        end
        MEM_WRITE: begin
          memWrite = 1'b1;
          iOrD     = 1'b1;
        end
        R_EXEC: begin
          aluSrcA = 1'b1;
          aluOp   = ALU_FN;
        end
        R_WB: begin
          regWrite = 1'b1;
          regDst   = 1'b1;
        end
        I_EXEC: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          case (opq)
            OP_ORI:  aluOp = ALU_OR;
            OP_ANDI: aluOp = ALU_AND;
            default: aluOp = ALU_ADD;
          endcase
          zeroExt = (opq == OP_ANDI) || (opq == OP_ORI);
        end
        I_WB: regWrite = 1'b1;
        BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = ALU_SUB;
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
        end
        JUMP: begin
          pcWrite  = 1'b1;
          pcSource = 2'b10;
        end
        ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and control
// word are queued as stimulus is driven and compared when the DUT shows them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       memReady = 1'b0;

  logic [3:0] state;
  logic [2:0] aluOp;
  logic       aluSrcA, zeroExt, pcWrite, pcWriteCond, iOrD, memRead, memWrite;
  logic       irWrite, regDst, memToReg, regWrite, illegal;
  logic [1:0] aluSrcB, pcSource, ldMode;

  multicycle_control #(.ALU_OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .state(state), .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .zeroExt(zeroExt), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .pcSource(pcSource), .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
    .regWrite(regWrite), .ldMode(ldMode), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [20:0] outs;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [20:0] obs = {aluOp, aluSrcA, aluSrcB, zeroExt, pcWrite, pcWriteCond,
                     pcSource, iOrD, memRead, memWrite, irWrite, regDst,
                     memToReg, regWrite, ldMode, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word for a given state, instruction opcode and memReady.
  function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic mr, input logic rn);
    logic [2:0] a_op;
    logic [1:0] src_b, pc_src, ld;
    logic       src_a, zx, pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, ill;
    a_op = 3'b000; src_b = 2'b00; pc_src = 2'b00; ld = 2'b00;
    src_a = 0; zx = 0; pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0;
    irw = 0; rdst = 0; m2r = 0; rw = 0; ill = 0;
    if (rn) begin
      case (st)
        4'd0:  begin mrd = 1; src_b = 2'b01; irw = mr; pcw = mr; end
        4'd1:  src_b = 2'b11;
        4'd2:  begin src_a = 1; src_b = 2'b10; end
        4'd3:  begin mrd = 1; iord = 1; end
        4'd4:  begin
          rw = 1; m2r = 1;
          ld = (op == 6'b100001) ? 2'b10 : (op == 6'b100101) ? 2'b11 : 2'b00;
        end
        4'd5:  begin mwr = 1; iord = 1; end
        4'd6:  begin src_a = 1; a_op = 3'b100; end
        4'd7:  begin rw = 1; rdst = 1; end
        4'd8:  begin
          src_a = 1; src_b = 2'b10;
          if (op == 6'b001101) begin a_op = 3'b010; zx = 1; end
          if (op == 6'b001100) begin a_op = 3'b011; zx = 1; end
        end
        4'd9:  rw = 1;
        4'd10: begin src_a = 1; a_op = 3'b001; pcwc = 1; pc_src = 2'b01; end
        4'd11: begin pcw = 1; pc_src = 2'b10; end
        4'd12: ill = 1;
        default: ;
      endcase
    end
    return {a_op, src_a, src_b, zx, pcw, pcwc, pc_src, iord, mrd, mwr, irw,
            rdst, m2r, rw, ld, ill};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic drive(input logic [5:0] op, input logic mr, input logic rn,
                       input logic [3:0] exp_st, input string tag);
    exp_t e;
    opcode = op;
    memReady = mr;
    rst_n = rn;
    sbq.push_back('{exp_st, model(exp_st, op, mr, rn), tag});
    @(negedge clk);
    e = sbq.pop_front();
    chk({e.tag, "_st"}, 32'(state), 32'(e.st));
    chk({e.tag, "_out"}, 32'(obs), 32'(e.outs));
    chk({e.tag, "_excl"}, {30'd0, memRead & memWrite, regWrite & (pcWrite | pcWriteCond)}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] hexv(input byte c);
    if (c >= "a") return 4'(c - "a" + 10);
    return 4'(c - "0");
  endfunction

  // sts: expected state per cycle (hex digit); mrs: memReady per cycle, 'x' = random.
  task automatic instr(input string nm, input logic [5:0] op, input string sts, input string mrs);
    logic mr;
    for (int i = 0; i < sts.len(); i++) begin
      if (mrs.getc(i) == "x") mr = 1'($urandom_range(0, 1));
      else mr = (mrs.getc(i) == "1");
      drive(op, mr, 1'b1, hexv(sts.getc(i)), $sformatf("%s%0d", nm, i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    memReady = 1'b1;
    @(posedge clk);
    #1;
    drive(6'd0, 1'b1, 1'b0, 4'd0, "rst_a");
    drive(6'd0, 1'b1, 1'b0, 4'd0, "rst_b");

    // lw abandoned by reset while stalled in MEM_READ
    instr("lwpre", 6'b100011, "0123", "1x00");
    drive(6'b100011, 1'b0, 1'b0, 4'd3, "midrst_a");
    drive(6'b100011, 1'b0, 1'b0, 4'd0, "midrst_b");
    drive(6'b100011, 1'b0, 1'b1, 4'd0, "postrst");

    instr("radd", 6'b000000, "0167",    "1xxx");
    instr("lh",   6'b100001, "0123334", "1xx001x");
    instr("sw",   6'b101011, "0000125", "00011x1");
    instr("ori",  6'b001101, "0189",    "1xxx");
    instr("andi", 6'b001100, "0189",    "1xxx");
    instr("addi", 6'b001000, "0189",    "1xxx");
    instr("lw",   6'b100011, "01234",   "1xx1x");
    instr("lhu",  6'b100101, "01234",   "1xx1x");
    instr("swst", 6'b101011, "01255",   "1xx01");
    instr("beq",  6'b000100, "01a",     "1xx");
    instr("j",    6'b000010, "01b",     "1xx");
    instr("ill",  6'b111111, "01c",     "1xx");
    instr("jal",  6'b000011, "01c",     "1xx");
    instr("end",  6'b000000, "0",       "0");

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
